// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - pipeline hazard controller with shadow EX/MEM/WB slots, stall/bubble and forwarding selects
module hazard_scheduler #(
    parameter bit FORWARD_EN = 1'b1,
    parameter bit RF_BYPASS  = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic             stall,
    output logic             bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    // Source registers are only needed while an instruction sits in EX.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
        logic [4:0] rs;
        logic [4:0] rt;
    } ex_slot_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
    } prod_slot_t;

    ex_slot_t         ex_q, ex_d;
    prod_slot_t       mem_q, mem_d;
    prod_slot_t       wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic dep_ex, dep_mem, dep_wb, hazard;

    function automatic logic produces(input logic v, input logic rw, input logic [4:0] rd,
                                      input logic [4:0] r);
        return v & rw & (rd == r) & (r != 5'd0);
    endfunction

    always_comb begin
        dep_ex  = id_valid & ((id_rs_used & produces(ex_q.valid, ex_q.regwrite, ex_q.rd, id_rs)) |
                              (id_rt_used & produces(ex_q.valid, ex_q.regwrite, ex_q.rd, id_rt)));
        dep_mem = id_valid & ((id_rs_used & produces(mem_q.valid, mem_q.regwrite, mem_q.rd, id_rs)) |
                              (id_rt_used & produces(mem_q.valid, mem_q.regwrite, mem_q.rd, id_rt)));
        dep_wb  = id_valid & ((id_rs_used & produces(wb_q.valid, wb_q.regwrite, wb_q.rd, id_rs)) |
                              (id_rt_used & produces(wb_q.valid, wb_q.regwrite, wb_q.rd, id_rt)));

        if (FORWARD_EN) begin
            hazard = dep_ex & ex_q.memread;
        end else begin
            hazard = dep_ex | dep_mem | (!RF_BYPASS && dep_wb);
        end

        // Flush wins: the ID instruction is dropped, so holding it would be wrong.
        stall  = hazard & ~flush;
        bubble = hazard | flush | ~id_valid;
    end

    always_comb begin
        ex_d = '{valid: ~bubble, rd: id_rd, regwrite: id_regwrite, memread: id_memread,
                 rs: id_rs, rt: id_rt};
        mem_d = '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite};
        wb_d  = mem_q;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // MEM outranks WB because it holds the younger write to the same register.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (FORWARD_EN && ex_q.valid) begin
            if (produces(mem_q.valid, mem_q.regwrite, mem_q.rd, ex_q.rs)) begin
                fwd_a = 2'b10;
            end else if (produces(wb_q.valid, wb_q.regwrite, wb_q.rd, ex_q.rs)) begin
                fwd_a = 2'b01;
            end
            if (produces(mem_q.valid, mem_q.regwrite, mem_q.rd, ex_q.rt)) begin
                fwd_b = 2'b10;
            end else if (produces(wb_q.valid, wb_q.regwrite, wb_q.rd, ex_q.rt)) begin
                fwd_b = 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
